pps_pulse_generator: RTL and testbench

Programmable pulse-train generator triggered by the PPS reference. Once armed, it waits for a PPS rising edge, counts a programmed delay, then emits a programmed number of pulses with set width and period. Its output `o_pulse` is the generated-pulse source feeding the output channel multiplexer, where it is selected against the divided PPS.

---
 rtl/pps_pulse_pkg.sv | 15 +
 rtl/pps_edge_sync.sv | 36 +++
 rtl/pps_pulse_generator.sv | 159 +++++++++++++++
 tb/tb_pps_pulse_generator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pps_pulse_pkg.sv
// Shared types and defaults for the PPS-triggered pulse-train generator.
package pps_pulse_pkg;

  localparam int DEFAULT_CNT_W = 32;
  localparam int DEFAULT_NUM_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    HIGH,
    LOW
  } PulseState;

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// one-cycle rising-edge strobe; also used by the PPS divider path.
module pps_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic r_levelPrev;
  logic r_rise;

  // The extra level stage fixes the strobe at three cycles after the first
  // sampling edge, which the downstream latency budget depends on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_level     <= 1'b0;
      r_levelPrev <= 1'b0;
      r_rise      <= 1'b0;
    end else begin
      r_sync1     <= i_in;
      r_sync2     <= r_sync1;
      r_level     <= r_sync2;
      r_levelPrev <= r_level;
      r_rise      <= r_level & ~r_levelPrev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/pps_pulse_generator.sv
// Armed by a strobe, waits for a PPS rising edge, counts a delay and then
// emits a finite or continuous train of pulses with programmed width/period.
module pps_pulse_generator
  import pps_pulse_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int NUM_W = DEFAULT_NUM_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pps,
  input  logic             i_enable,
  input  logic             i_arm,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_high,
  input  logic [CNT_W-1:0] i_period,
  input  logic [NUM_W-1:0] i_count,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_armed,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  PulseState        r_state;
  PulseState        w_nextState;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phaseNext;
  logic [NUM_W-1:0] r_pulseNum;
  logic [NUM_W-1:0] w_pulseNumNext;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_low;
  logic [NUM_W-1:0] r_count;
  logic             r_pulse;
  logic             r_busy;
  logic             r_armed;
  logic             r_done;
  logic             w_ppsRise;
  logic             w_armAccept;
  logic             w_doneNext;
  logic [CNT_W-1:0] w_highClamped;
  logic [CNT_W-1:0] w_periodClamped;
  logic [CNT_W-1:0] w_lowLen;

  pps_edge_sync u_ppsSync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_in   (i_pps),
    .o_rise (w_ppsRise)
  );

  assign w_armAccept     = i_enable & i_arm;
  assign w_highClamped   = (i_high == '0) ? CNT_ONE : i_high;
  assign w_periodClamped = (i_period <= w_highClamped) ? (w_highClamped + CNT_ONE) : i_period;
  assign w_lowLen        = w_periodClamped - w_highClamped;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Enable and arm override every state; otherwise one shared phase counter
  // times whichever interval the current state represents.
  always_comb begin
    w_nextState    = r_state;
    w_phaseNext    = r_phase + CNT_ONE;
    w_pulseNumNext = r_pulseNum;
    w_doneNext     = 1'b0;
    if (!i_enable) begin
      w_nextState = IDLE;
      w_phaseNext = '0;
    end else if (i_arm) begin
      w_nextState    = ARMED;
      w_phaseNext    = '0;
      w_pulseNumNext = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_phaseNext = '0;
        end
        ARMED: begin
          w_phaseNext = '0;
          if (w_ppsRise) begin
            w_nextState = (r_delay == '0) ? HIGH : DELAY;
          end
        end
        DELAY: begin
          if (r_phase == r_delay - CNT_ONE) begin
            w_nextState = HIGH;
            w_phaseNext = '0;
          end
        end
        HIGH: begin
          if (r_phase == r_high - CNT_ONE) begin
            w_nextState = LOW;
            w_phaseNext = '0;
          end
        end
        LOW: begin
          if (r_phase == r_low - CNT_ONE) begin
            w_phaseNext = '0;
            if ((r_count != '0) && (r_pulseNum == r_count - NUM_ONE)) begin
              w_nextState = IDLE;
              w_doneNext  = 1'b1;
            end else begin
              w_nextState    = HIGH;
              w_pulseNumNext = r_pulseNum + NUM_ONE;
            end
          end
        end
        default: begin
          w_nextState = IDLE;
          w_phaseNext = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase    <= '0;
      r_pulseNum <= '0;
      r_delay    <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_count    <= '0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_phase    <= w_phaseNext;
      r_pulseNum <= w_pulseNumNext;
      r_pulse    <= (w_nextState == HIGH);
      r_busy     <= (w_nextState == DELAY) || (w_nextState == HIGH) || (w_nextState == LOW);
      r_armed    <= (w_nextState == ARMED);
      r_done     <= w_doneNext;
      if (w_armAccept) begin
        r_delay <= i_delay;
        r_high  <= w_highClamped;
        r_low   <= w_lowLen;
        r_count <= i_count;
      end
    end
  end

  assign o_pulse = r_pulse;
  assign o_busy  = r_busy;
  assign o_armed = r_armed;
  assign o_done  = r_done;

endmodule

// File: tb/tb_pps_pulse_generator.sv
// Scoreboard bench: stimulus pushes expected pulses/done strobes computed from
// the timing rules; an independent monitor pops and compares on DUT activity.
module tb_pps_pulse_generator;

  localparam longint INF = 64'h7fff_ffff_ffff_ffff;

  typedef struct {
    longint rise;
    longint width;
  } PulseExp;

  logic        clk;
  logic        rst;
  logic        pps;
  logic        enable;
  logic        arm;
  logic [31:0] delay;
  logic [31:0] high;
  logic [31:0] period;
  logic [15:0] count;
  logic        pulse;
  logic        busy;
  logic        armed;
  logic        done;

  longint  cyc = 0;
  int      nTests = 0;
  int      nFail = 0;
  PulseExp pulseQ[$];
  longint  doneQ[$];
  longint  riseCyc = 0;
  logic    prevPulse = 1'b0;

  pps_pulse_generator dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pps    (pps),
    .i_enable (enable),
    .i_arm    (arm),
    .i_delay  (delay),
    .i_high   (high),
    .i_period (period),
    .i_count  (count),
    .o_pulse  (pulse),
    .o_busy   (busy),
    .o_armed  (armed),
    .o_done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // After posedge number e, cyc == e; outputs are observed on the negedge.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic noteUnexpected(input string name, input longint actual);
    nTests++;
    nFail++;
    $display("[TB] FAIL %s: got event at cycle %0d, expected none", name, actual);
  endtask

  // Reference model: e0 is the clock edge that first samples pps=1; pulses
  // cut short by an abort (arm, enable low or reset) sampled at abortEdge.
  task automatic pushTrain(input longint e0, input int d, input int h, input int p,
                           input int c, input longint abortEdge, output longint endEdge);
    longint hh, pp, first, r, fall, doneE;
    PulseExp e;
    hh = (h == 0) ? 1 : h;
    pp = (p <= hh) ? hh + 1 : p;
    first = e0 + d + 4;
    for (longint k = 0; (c == 0) || (k < c); k++) begin
      r = first + k * pp;
      if (r >= abortEdge) break;
      fall = (r + hh < abortEdge) ? r + hh : abortEdge;
      e.rise = r;
      e.width = fall - r;
      pulseQ.push_back(e);
    end
    endEdge = abortEdge;
    if (c != 0) begin
      doneE = first + c * pp;
      if (doneE < abortEdge) begin
        doneQ.push_back(doneE);
        endEdge = doneE;
      end
    end
  endtask

  always @(negedge clk) begin
    PulseExp e;
    if (pulse && !prevPulse) riseCyc = cyc;
    if (!pulse && prevPulse) begin
      if (pulseQ.size() == 0) begin
        noteUnexpected("pulse_unexpected", riseCyc);
      end else begin
        e = pulseQ.pop_front();
        checkOutput("pulse_rise_cycle", riseCyc, e.rise);
        checkOutput("pulse_width", cyc - riseCyc, e.width);
      end
    end
    prevPulse = pulse;
    if (done) begin
      if (doneQ.size() == 0) noteUnexpected("done_unexpected", cyc);
      else checkOutput("done_cycle", cyc, doneQ.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitUntilCyc(input longint n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called on a negedge; the arm is sampled at the next posedge and the live
  // inputs are scrambled afterwards to show they are not looked at again.
  task automatic applyStimulus(input int d, input int h, input int p, input int c);
    delay  = d;
    high   = h;
    period = p;
    count  = 16'(c);
    arm    = 1'b1;
    @(negedge clk);
    arm    = 1'b0;
    delay  = $urandom;
    high   = $urandom;
    period = $urandom;
    count  = 16'($urandom);
    checkOutput("armed_after_arm", longint'(armed), 1);
  endtask

  task automatic ppsRaise(output longint e0);
    pps = 1'b1;
    e0 = cyc + 1;
  endtask

  initial begin
    longint e0, e1, x, endE;
    int d, h, p, c;

    rst = 1'b1; pps = 1'b0; enable = 1'b1; arm = 1'b0;
    delay = '0; high = '0; period = '0; count = '0;
    idle(3);
    rst = 1'b0;
    checkOutput("reset_pulse", longint'(pulse), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_armed", longint'(armed), 0);
    checkOutput("reset_done", longint'(done), 0);
    idle(3);

    // Basic finite train
    applyStimulus(10, 5, 20, 3);
    idle(2);
    ppsRaise(e0);
    pushTrain(e0, 10, 5, 20, 3, INF, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(endE + 3);
    checkOutput("basic_busy_after", longint'(busy), 0);
    checkOutput("basic_armed_after", longint'(armed), 0);

    // Clamping of zero high/period and zero delay
    applyStimulus(0, 0, 0, 2);
    ppsRaise(e0);
    pushTrain(e0, 0, 0, 0, 2, INF, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(endE + 3);

    // Continuous train stopped by enable low partway into a HIGH phase
    applyStimulus(5, 3, 8, 0);
    ppsRaise(e0);
    x = e0 + 5 + 4 + 1000 * 8 + 2;
    pushTrain(e0, 5, 3, 8, 0, x, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(x - 1);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disable_pulse", longint'(pulse), 0);
    checkOutput("disable_busy", longint'(busy), 0);
    checkOutput("disable_armed", longint'(armed), 0);
    enable = 1'b1;
    idle(5);
    ppsRaise(e1);
    idle(4); pps = 1'b0;
    idle(30);
    checkOutput("disable_stays_idle", longint'(busy), 0);

    // Re-arm in the middle of pulse 2 with new random values
    applyStimulus(4, 6, 15, 5);
    ppsRaise(e0);
    x = e0 + 4 + 4 + 15 + 3;
    pushTrain(e0, 4, 6, 15, 5, x, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(x - 1);
    d = $urandom_range(0, 20); h = $urandom_range(0, 8);
    p = $urandom_range(0, 25); c = $urandom_range(1, 4);
    applyStimulus(d, h, p, c);
    checkOutput("rearm_pulse_low", longint'(pulse), 0);
    checkOutput("rearm_busy", longint'(busy), 0);
    idle(5);
    ppsRaise(e1);
    pushTrain(e1, d, h, p, c, INF, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(endE + 3);

    // Second PPS edge during DELAY must not retrigger
    applyStimulus(30, 4, 10, 2);
    ppsRaise(e0);
    pushTrain(e0, 30, 4, 10, 2, INF, endE);
    idle(3); pps = 1'b0;
    idle(8); pps = 1'b1;
    idle(3); pps = 1'b0;
    waitUntilCyc(endE + 3);

    // Arm coincident with the internal PPS strobe: arm wins, wait for next PPS
    applyStimulus(7, 2, 9, 2);
    ppsRaise(e0);
    waitUntilCyc(e0 + 3);
    d = $urandom_range(0, 12); h = $urandom_range(1, 5);
    p = $urandom_range(6, 14); c = $urandom_range(1, 3);
    applyStimulus(d, h, p, c);
    pps = 1'b0;
    idle(12);
    checkOutput("collision_still_armed", longint'(armed), 1);
    checkOutput("collision_not_busy", longint'(busy), 0);
    ppsRaise(e1);
    pushTrain(e1, d, h, p, c, INF, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(endE + 3);

    // Reset during LOW of pulse 2 of 4, then an un-armed PPS
    applyStimulus(3, 4, 12, 4);
    ppsRaise(e0);
    x = e0 + 3 + 4 + 12 + 6;
    pushTrain(e0, 3, 4, 12, 4, x, endE);
    idle(4); pps = 1'b0;
    waitUntilCyc(x - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_pulse", longint'(pulse), 0);
    checkOutput("midreset_busy", longint'(busy), 0);
    checkOutput("midreset_armed", longint'(armed), 0);
    checkOutput("midreset_done", longint'(done), 0);
    idle(5);
    ppsRaise(e1);
    idle(4); pps = 1'b0;
    idle(60);
    checkOutput("postreset_idle_busy", longint'(busy), 0);

    // Randomized finite trains
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 15); h = $urandom_range(0, 6);
      p = $urandom_range(0, 14); c = $urandom_range(1, 4);
      applyStimulus(d, h, p, c);
      idle($urandom_range(0, 5));
      ppsRaise(e0);
      pushTrain(e0, d, h, p, c, INF, endE);
      idle(4); pps = 1'b0;
      waitUntilCyc(endE + 3);
      checkOutput("random_busy_after", longint'(busy), 0);
    end

    idle(20);
    checkOutput("pulse_queue_drained", pulseQ.size(), 0);
    checkOutput("done_queue_drained", doneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
